obi_dp_ram_bridge: RTL and testbench

OBI_DP_RAM_BRIDGE -- requirements
Module: obi_dp_ram_bridge

---
 rtl/obi_dp_ram_bridge_pkg.sv | 20 ++
 rtl/obi_resp_fifo.sv | 74 +++++++
 rtl/obi_dp_ram_bridge.sv | 148 ++++++++++++++
 tb/tb_obi_dp_ram_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_dp_ram_bridge_pkg.sv
// Shared types for the OBI data-port to single-port RAM bridge.
`timescale 1ns/1ps
package obi_dp_ram_bridge_pkg;

    localparam int unsigned OBI_DW = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        GRANT
    } gnt_state_e;

    typedef struct packed {
        logic [OBI_DW-1:0] rdata;
        logic              err;
        logic [CNT_W-1:0]  cnt;
    } resp_entry_t;

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue; the head counts down its delay and pops when it reaches zero.
// An entry pushed into an empty queue is the head in its push cycle, so zero delay bypasses storage.
`timescale 1ns/1ps
module obi_resp_fifo
    import obi_dp_ram_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  resp_entry_t       push_entry,
    output logic              pop,
    output logic [OBI_DW-1:0] pop_rdata,
    output logic              pop_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    resp_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [OCC_W-1:0]   occ_q;

    logic               empty_c;
    logic               store_c;
    logic               take_c;
    resp_entry_t        head_c;
    resp_entry_t        dec_entry_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty_c         = (occ_q == '0);
        head_c          = empty_c ? push_entry : mem_q[rd_ptr_q];
        pop             = (!empty_c || push) && (head_c.cnt == '0);
        dec_entry_c     = push_entry;
        dec_entry_c.cnt = push_entry.cnt - CNT_W'(1);
        // a bypassing entry is stored only if it still has delay left
        store_c         = empty_c ? (push && !pop) : push;
        take_c          = !empty_c && pop;
    end

    assign pop_rdata = head_c.rdata;
    assign pop_err   = head_c.err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (!empty_c && (head_c.cnt != '0)) begin
                mem_q[rd_ptr_q].cnt <= head_c.cnt - CNT_W'(1);
            end
            if (store_c) begin
                mem_q[wr_ptr_q] <= empty_c ? dec_entry_c : push_entry;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (take_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({store_c, take_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_dp_ram_bridge.sv
// OBI data-port slave driving a synchronous RAM, with programmable grant stall
// and response delay for exercising core-side handshake timing.
`timescale 1ns/1ps
module obi_dp_ram_bridge
    import obi_dp_ram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [31:0]           obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [3:0]            obi_be_i,
    input  logic [OBI_DW-1:0]     obi_wdata_i,
    output logic                  obi_rvalid_o,
    output logic [OBI_DW-1:0]     obi_rdata_o,
    output logic                  obi_err_o,
    input  logic [1:0]            gnt_stall_i,
    input  logic [1:0]            rvalid_dly_i,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [OBI_DW-1:0]     ram_wdata_o,
    output logic [3:0]            ram_be_o,
    input  logic [OBI_DW-1:0]     ram_rdata_i
);

    localparam int unsigned OUT_W = $clog2(DEPTH + 1);

    gnt_state_e         state_q, state_d;
    logic [1:0]         stall_q, stall_d;
    logic [OUT_W-1:0]   out_q;
    logic               gnt_c;
    logic               slot_free_c;
    logic               in_range_c;
    logic               access_c;

    logic               pend_q;
    logic               pend_rd_q;
    logic               pend_err_q;
    logic [CNT_W-1:0]   pend_cnt_q;

    resp_entry_t        push_entry_c;
    logic               rvalid_c;
    logic [OBI_DW-1:0]  head_rdata_c;
    logic               head_err_c;

    assign slot_free_c = (out_q < OUT_W'(DEPTH));
    assign in_range_c  = ((obi_addr_i >> ADDR_WIDTH) == '0);

    // stall_q holds the stall cycles still to come after the current one
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        gnt_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (obi_req_i) begin
                    if (gnt_stall_i == 2'd0) begin
                        gnt_c = slot_free_c;
                    end else begin
                        stall_d = gnt_stall_i - 2'd1;
                        state_d = (gnt_stall_i == 2'd1) ? GRANT : STALL;
                    end
                end
            end
            STALL: begin
                if (!obi_req_i) begin
                    state_d = IDLE;
                end else begin
                    stall_d = stall_q - 2'd1;
                    if (stall_q == 2'd1) begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (!obi_req_i) begin
                    state_d = IDLE;
                end else if (slot_free_c) begin
                    gnt_c   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // address-phase outputs are combinational; held low throughout reset
    assign obi_gnt_o   = rst_ni && gnt_c;
    assign access_c    = obi_req_i && obi_gnt_o;
    assign ram_en_o    = access_c && in_range_c;
    assign ram_we_o    = rst_ni && obi_we_i;
    assign ram_addr_o  = rst_ni ? obi_addr_i[ADDR_WIDTH-1:0] : '0;
    assign ram_wdata_o = rst_ni ? obi_wdata_i : '0;
    assign ram_be_o    = rst_ni ? obi_be_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            stall_q    <= '0;
            out_q      <= '0;
            pend_q     <= 1'b0;
            pend_rd_q  <= 1'b0;
            pend_err_q <= 1'b0;
            pend_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            pend_q     <= access_c;
            pend_rd_q  <= access_c && in_range_c && !obi_we_i;
            pend_err_q <= access_c && !in_range_c;
            pend_cnt_q <= rvalid_dly_i;
            unique case ({access_c, rvalid_c})
                2'b10:   out_q <= out_q + OUT_W'(1);
                2'b01:   out_q <= out_q - OUT_W'(1);
                default: out_q <= out_q;
            endcase
        end
    end

    // RAM data arrives the cycle after the access, so the entry is built then
    always_comb begin
        push_entry_c.rdata = pend_rd_q ? ram_rdata_i : '0;
        push_entry_c.err   = pend_err_q;
        push_entry_c.cnt   = pend_cnt_q;
    end

    obi_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (pend_q),
        .push_entry (push_entry_c),
        .pop        (rvalid_c),
        .pop_rdata  (head_rdata_c),
        .pop_err    (head_err_c)
    );

    assign obi_rvalid_o = rvalid_c;
    assign obi_rdata_o  = rvalid_c ? head_rdata_c : '0;
    assign obi_err_o    = rvalid_c && head_err_c;

endmodule

// File: tb/tb_obi_dp_ram_bridge.sv
// Directed self-checking bench for obi_dp_ram_bridge with a byte-enabled RAM model.
`timescale 1ns/1ps
module tb_obi_dp_ram_bridge;

    localparam int unsigned AW = 22;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [1:0]  gnt_stall_i;
    logic [1:0]  rvalid_dly_i;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_rdata_i;

    int n_cmp = 0;
    int n_bad = 0;

    obi_dp_ram_bridge #(.ADDR_WIDTH(AW), .DEPTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .gnt_stall_i  (gnt_stall_i),
        .rvalid_dly_i (rvalid_dly_i),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_be_o     (ram_be_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // synchronous RAM: read data valid the cycle after the enable
    logic [31:0] mem [1024];
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) mem[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
                end
            end else begin
                ram_rdata_i <= mem[ram_addr_o[11:2]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit req, input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        @(negedge clk_i);
        obi_req_i   = req;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        int gcyc, rvcyc, en_n, en_gnt, hits, idx, rv_n;
        int gc [3];
        int rc [3];
        logic [31:0] rvdat;
        logic [31:0] exp_rd [3];

        rst_ni       = 1'b0;
        obi_req_i    = 1'b0;
        obi_we_i     = 1'b0;
        obi_addr_i   = '0;
        obi_be_i     = '0;
        obi_wdata_i  = '0;
        gnt_stall_i  = 2'd0;
        rvalid_dly_i = 2'd0;
        ram_rdata_i  = '0;

        // outputs held low in reset even with a request present
        drive(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        check("rst_gnt", 32'(obi_gnt_o), 32'd0);
        check("rst_ram_en", 32'(ram_en_o), 32'd0);
        check("rst_ram_we", 32'(ram_we_o), 32'd0);
        check("rst_ram_wdata", ram_wdata_o, 32'h0);
        check("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // write then read back with zero stall / delay
        drive(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        check("wr_gnt", 32'(obi_gnt_o), 32'd1);
        check("wr_ram_en", 32'(ram_en_o), 32'd1);
        check("wr_ram_addr", 32'(ram_addr_o), 32'h100);
        check("wr_rvalid_early", 32'(obi_rvalid_o), 32'd0);
        drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        check("rd_gnt", 32'(obi_gnt_o), 32'd1);
        check("wr_rvalid", 32'(obi_rvalid_o), 32'd1);
        check("wr_rdata", obi_rdata_o, 32'h0);
        check("wr_err", 32'(obi_err_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("rd_rvalid", 32'(obi_rvalid_o), 32'd1);
        check("rd_rdata", obi_rdata_o, 32'hDEADBEEF);
        check("rd_err", 32'(obi_err_o), 32'd0);
        idle(1);
        check("quiet_rvalid", 32'(obi_rvalid_o), 32'd0);
        check("quiet_rdata", obi_rdata_o, 32'h0);

        // three-cycle grant stall
        gnt_stall_i = 2'd3;
        gcyc = -1; rvcyc = -1; en_n = 0; en_gnt = 0; rvdat = '0;
        for (int k = 0; k < 8; k++) begin
            drive(gcyc < 0, 1'b0, 32'h100, 4'hF, 32'h0);
            if (obi_gnt_o) gcyc = k;
            if (ram_en_o) begin en_n++; if (obi_gnt_o) en_gnt++; end
            if (obi_rvalid_o) begin rvcyc = k; rvdat = obi_rdata_o; end
        end
        check("stall_gnt_cycle", 32'(gcyc), 32'd3);
        check("stall_en_count", 32'(en_n), 32'd1);
        check("stall_en_at_gnt", 32'(en_gnt), 32'd1);
        check("stall_rv_cycle", 32'(rvcyc), 32'd4);
        check("stall_rdata", rvdat, 32'hDEADBEEF);

        // request withdrawn during stall: no access, no response
        gnt_stall_i = 2'd2;
        hits = 0;
        drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        if (obi_gnt_o || ram_en_o || obi_rvalid_o) hits++;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (obi_gnt_o || ram_en_o || obi_rvalid_o) hits++;
        end
        check("abort_activity", 32'(hits), 32'd0);
        gnt_stall_i = 2'd0;

        // back-to-back reads against a full outstanding window
        exp_rd[0] = 32'hA1A1_0010;
        exp_rd[1] = 32'hA2A2_0014;
        exp_rd[2] = 32'hA3A3_0018;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'h10 + 32'(4*i), 4'hF, exp_rd[i]);
        idle(2);
        rvalid_dly_i = 2'd2;
        idx = 0; rv_n = 0;
        for (int i = 0; i < 3; i++) begin gc[i] = -1; rc[i] = -1; end
        for (int k = 0; k < 14; k++) begin
            drive(idx < 3, 1'b0, 32'h10 + 32'(4*idx), 4'hF, 32'h0);
            if (obi_rvalid_o && rv_n < 3) begin
                rc[rv_n] = k;
                check("b2b_rdata", obi_rdata_o, exp_rd[rv_n]);
                rv_n++;
            end
            if (obi_gnt_o && idx < 3) begin gc[idx] = k; idx++; end
        end
        check("b2b_gnt0", 32'(gc[0]), 32'd0);
        check("b2b_gnt1", 32'(gc[1]), 32'd1);
        check("b2b_gnt2_held", 32'(gc[2] >= rc[0] && gc[2] <= rc[0] + 1 && rc[0] >= 0), 32'd1);
        check("b2b_rv0", 32'(rc[0]), 32'd3);
        check("b2b_rv1", 32'(rc[1]), 32'd6);
        check("b2b_rv2", 32'(rc[2]), 32'd9);
        check("b2b_rv_count", 32'(rv_n), 32'd3);

        // out-of-range read and write
        rvalid_dly_i = 2'd0;
        drive(1'b1, 1'b0, 32'h0040_0000, 4'hF, 32'h0);
        check("oor_rd_gnt", 32'(obi_gnt_o), 32'd1);
        check("oor_rd_en", 32'(ram_en_o), 32'd0);
        drive(1'b1, 1'b1, 32'h0040_0004, 4'hF, 32'h5555_5555);
        check("oor_wr_en", 32'(ram_en_o), 32'd0);
        check("oor_rd_rvalid", 32'(obi_rvalid_o), 32'd1);
        check("oor_rd_err", 32'(obi_err_o), 32'd1);
        check("oor_rd_rdata", obi_rdata_o, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("oor_wr_rvalid", 32'(obi_rvalid_o), 32'd1);
        check("oor_wr_err", 32'(obi_err_o), 32'd1);
        idle(1);
        check("oor_err_idle", 32'(obi_err_o), 32'd0);

        // reset with two responses pending
        rvalid_dly_i = 2'd3;
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drive(1'b1, 1'b0, 32'h14, 4'hF, 32'h0);
        @(negedge clk_i);
        #2;
        rst_ni      = 1'b0;
        obi_req_i   = 1'b1;
        obi_we_i    = 1'b1;
        obi_wdata_i = 32'hFFFF_FFFF;
        #1;
        check("mid_rst_gnt", 32'(obi_gnt_o), 32'd0);
        check("mid_rst_en", 32'(ram_en_o), 32'd0);
        check("mid_rst_wdata", ram_wdata_o, 32'h0);
        check("mid_rst_rvalid", 32'(obi_rvalid_o), 32'd0);
        @(posedge clk_i);
        rvalid_dly_i = 2'd0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        obi_we_i    = 1'b0;
        obi_addr_i  = 32'h18;
        obi_wdata_i = '0;
        #1;
        check("post_rst_gnt", 32'(obi_gnt_o), 32'd1);
        hits = 0; rvdat = '0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (obi_rvalid_o) begin hits++; if (k == 0) rvdat = obi_rdata_o; end
        end
        check("post_rst_rv_count", 32'(hits), 32'd1);
        check("post_rst_rdata", rvdat, 32'hA3A3_0018);

        // byte-enabled write merge
        drive(1'b1, 1'b1, 32'h200, 4'hF, 32'h1122_3344);
        drive(1'b1, 1'b1, 32'h200, 4'h2, 32'h0000_AB00);
        check("be_ram_be", 32'(ram_be_o), 32'h2);
        check("be_ram_wdata", ram_wdata_o, 32'h0000_AB00);
        drive(1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("be_rvalid", 32'(obi_rvalid_o), 32'd1);
        check("be_rdata", obi_rdata_o, 32'h1122_AB44);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
